uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
Buffered UART transmitter. It accepts bytes on a valid/ready stream sink and queues them in an internal FIFO. Each byte is serialised onto a single idle-high line as start, 8 data bits (LSB first), optional parity, and 1 or 2 stop bits. It is the transmit-side counterpart to uart_rx. It adds queueing and framing options so that software-side producers can burst bytes without stalling on the line rate.

Parameters:
CLK_DIV, 69, clock cycles per bit (8 MHz clk / 115200 baud); legal range 2..65535
FIFO_DEPTH, 16, byte queue depth; power of two, 2..256
PARITY, uart_pkg::PARITY_NONE, one of PARITY_NONE / PARITY_EVEN / PARITY_ODD
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low
s_valid  input  1  stream sink: byte offered
s_ready  output  1  stream sink: byte can be accepted
s_data  input  8  stream sink: byte to send
tx  output  1  serial line, idle high
busy  output  1  high while a frame is on the line
level  output  $clog2(FIFO_DEPTH+1)  bytes currently queued (excludes the byte being shifted)

Behaviour:
- Reset (rst=0, async):
  - tx=1, busy=0, level=0, s_ready=0 while held.
  - FIFO emptied, FSM to IDLE, bit/cycle counters cleared.
  - A frame in progress is aborted immediately; the line returns high with no glitch low.
- After reset release: s_ready=1 from the first clk edge.
- s_ready = !full. It is registered from level, with no combinational path from the pop.
- A byte is accepted on an edge where s_valid && s_ready.
- Push when full is impossible, because s_ready is low.
- Pop and push on the same edge: level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START: on the edge where the FIFO is non-empty. The byte is popped into the shift register and tx<=0 on that same edge.
  - Latency: a byte accepted at edge E0 into an empty FIFO in IDLE drives tx low from E1.
  - START -> DATA: after CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; a 3-bit index wraps 7->exit.
  - DATA -> PARITY if PARITY != NONE, else DATA -> STOP.
  - PARITY: the bit is the XOR of the data for EVEN, and its inverse for ODD; lasts CLK_DIV cycles.
  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles.
  - At the final STOP cycle, if the FIFO is non-empty, go directly to START (pop, tx<=0) with zero idle cycles. Otherwise go to IDLE.
- Cycle counter: width $clog2(CLK_DIV). Counts 0..CLK_DIV-1, then advances the bit. No fractional-baud accumulation.
- busy=1 in START/DATA/PARITY/STOP, 0 in IDLE.
- tx is driven from a flop only.
- s_data is sampled only at acceptance; later changes to s_data have no effect.

Decomposition:
- uart_pkg:
  - parity_t enum (PARITY_NONE, PARITY_EVEN, PARITY_ODD).
  - tx_state_t enum.
  - constant UART_DATA_BITS = 8.
- Sub-module stream_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, data in/out, full, empty, count.
  - First-word data out registered; async active-low reset on the same rst.
- FSM, counters and the shift register stay in uart_tx_buffered.

Test Plan:
- Single byte 8'hAB, PARITY_NONE, STOP_BITS=1, CLK_DIV=69:
  - tx low one cycle after acceptance.
  - Line sequence 0,1,1,0,1,0,1,0,1,1, each bit 69 cycles.
  - busy drops after 690 cycles; uart_rx in loopback emits 8'hAB.
- 8'hAB with PARITY_EVEN -> parity bit 1.
- 8'hAB with PARITY_ODD -> parity bit 0.
- In both parity cases: frame 759 cycles, STOP_BITS=2 adds 69.
- Burst: 18 bytes 8'h00..8'h11, s_valid held high, FIFO_DEPTH=16:
  - 17 accepted (first popped immediately), then s_ready=0 and level=16.
  - Frames contiguous with no idle cycle between stop and next start.
  - Bytes arrive in order; s_ready reasserts on the edge after the first mid-burst pop.
- Reset mid-frame: assert rst during DATA bit 3 of 8'h55 with 3 bytes queued:
  - tx=1 and busy=0 asynchronously, level=0.
  - After release, no further frames; a new byte 8'hC3 transmits correctly.
- Slow producer: s_valid pulsed every 1000 cycles with 8'h0F, 8'hF0:
  - Two separate frames, each preceded by IDLE with tx=1.
  - level never exceeds 0 when observed outside the acceptance edge.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//   parity_t       - parity option for a frame (none / even / odd)
//   tx_state_t     - transmitter frame state
//   UART_DATA_BITS - payload bits per frame
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: first-word-fall-through queue with a registered head word.
//   clk, rst    - clock, asynchronous active-low reset
//   push / din  - write din (caller guarantees !full)
//   pop         - drop the head word (caller guarantees !empty)
//   dout        - head word, valid whenever !empty
//   full, empty - occupancy flags
//   count       - number of stored words
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    rd_next  = rd_ptr_q + AW'(1);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_next : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    dout_d   = dout_q;
    // The head register takes din directly when the incoming word becomes
    // the head; otherwise a pop pre-reads the next stored word.
    if (push && (count_q == '0 || (count_q == CW'(1) && pop))) begin
      dout_d = din;
    end else if (pop) begin
      dout_d = mem_q[rd_next];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = dout_q;
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: queued UART transmitter (start, 8 data LSB first,
// optional parity, 1 or 2 stop bits) on an idle-high line.
//   clk, rst         - clock, asynchronous active-low reset
//   s_valid/s_ready  - byte stream handshake, s_data sampled on acceptance
//   tx               - serial line, driven from a flop
//   busy             - high while a frame is on the line
//   level            - bytes waiting in the queue (not counting the one shifting)
module uart_tx_buffered import uart_pkg::*; #(
  parameter int      CLK_DIV    = 69,
  parameter int      FIFO_DEPTH = 16,
  parameter parity_t PARITY     = PARITY_NONE,
  parameter int      STOP_BITS  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [7:0]                      s_data,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(CLK_DIV);

  logic                      push, pop, load, cnt_done;
  logic [7:0]                fifo_dout;
  logic                      fifo_full, fifo_empty;

  tx_state_t                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      par_q, par_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      s_ready_q, s_ready_d;

  assign push = s_valid && s_ready_q;

  stream_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (level)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    load      = 1'b0;
    cnt_done  = (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d     = cnt_done ? '0 : cnt_q + CNT_W'(1);

    unique case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        load  = !fifo_empty;
      end
      TX_START: begin
        if (cnt_done) begin
          state_d   = TX_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
        end
      end
      TX_DATA: begin
        if (cnt_done) begin
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
            if (PARITY != PARITY_NONE) begin
              state_d = TX_PARITY;
              tx_d    = par_q;
            end else begin
              state_d   = TX_STOP;
              tx_d      = 1'b1;
              bit_idx_d = '0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          end
        end
      end
      TX_PARITY: begin
        if (cnt_done) begin
          state_d   = TX_STOP;
          tx_d      = 1'b1;
          bit_idx_d = '0;
        end
      end
      TX_STOP: begin
        // bit_idx counts stop bits here; the last stop cycle chains straight
        // into the next start bit when more bytes are queued.
        if (cnt_done) begin
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = TX_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    if (load) begin
      pop     = 1'b1;
      state_d = TX_START;
      tx_d    = 1'b0;
      cnt_d   = '0;
      shift_d = fifo_dout;
      par_d   = (^fifo_dout) ^ (PARITY == PARITY_ODD);
    end

    busy_d    = (state_d != TX_IDLE);
    // Pops are ignored here, so a freed slot is offered one edge later.
    s_ready_d = !(fifo_full || (push && level == CW'(FIFO_DEPTH - 1)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign s_ready = s_ready_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three instances (no parity/1 stop,
// even parity/2 stops, odd parity/1 stop) each followed cycle by cycle by a
// queue-and-timeline reference model, plus table vectors and hand sequences.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int DIV   = 69;
  localparam int DEPTH = 16;
  localparam int NI    = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NI-1:0]         vld;
  logic [NI-1:0][7:0]    dat;
  logic [NI-1:0]         rdy, txs, bsy;
  logic [NI-1:0][4:0]    lvl;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      uart_tx_buffered #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH),
        .PARITY     (parity_t'(gi)),
        .STOP_BITS  ((gi == 1) ? 2 : 1)
      ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (vld[gi]),
        .s_ready (rdy[gi]),
        .s_data  (dat[gi]),
        .tx      (txs[gi]),
        .busy    (bsy[gi]),
        .level   (lvl[gi])
      );
    end
  endgenerate

  // ---------------- reference model ----------------
  int         cyc;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] mq [NI][$];
  bit         act [NI];
  int         fstart [NI];
  int         fend [NI];
  logic [7:0] cur [NI];
  bit         m_rdy [NI];
  bit         last_acc [NI];

  function automatic int n_bits(int i);
    return 1 + 8 + ((i != 0) ? 1 : 0) + ((i == 1) ? 2 : 1);
  endfunction

  // Bit k of the frame for instance i carrying byte b (idle high past the end).
  function automatic logic frame_bit(int i, logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && i == 1) return ^b;
    if (k == 9 && i == 2) return ~(^b);
    return 1'b1;
  endfunction

  function automatic bit model_busy();
    for (int i = 0; i < NI; i++)
      if (act[i] || mq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      act[i]   = 1'b0;
      m_rdy[i] = 1'b0;
    end
  endtask

  task automatic model_edge(int i, bit acc, logic [7:0] d);
    bit popped = 1'b0;
    if (act[i] && cyc == fend[i]) act[i] = 1'b0;
    if (!act[i] && mq[i].size() != 0) begin
      cur[i]    = mq[i].pop_front();
      act[i]    = 1'b1;
      fstart[i] = cyc;
      fend[i]   = cyc + n_bits(i) * DIV;
      popped    = 1'b1;
    end
    if (acc) mq[i].push_back(d);
    m_rdy[i] = (mq[i].size() + int'(popped)) < DEPTH;
  endtask

  task automatic chk(string name, int i, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cycle %0d: got %0h, expected %0h", name, i, cyc, got, exp);
    end
  endtask

  // One clock edge: decide acceptance, advance model, compare all outputs.
  task automatic tick();
    bit         acc [NI];
    logic [7:0] ad [NI];
    logic       exp_tx;
    for (int i = 0; i < NI; i++) begin
      acc[i] = vld[i] && m_rdy[i];
      ad[i]  = dat[i];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      last_acc[i] = acc[i] && rst;
      if (rst) model_edge(i, acc[i], ad[i]);
      exp_tx = act[i] ? frame_bit(i, cur[i], (cyc - fstart[i]) / DIV) : 1'b1;
      chk("tx", i, txs[i], exp_tx);
      chk("busy", i, bsy[i], act[i]);
      chk("level", i, lvl[i], mq[i].size());
      chk("s_ready", i, rdy[i], m_rdy[i]);
    end
  endtask

  task automatic wait_idle(int bound);
    int t = 0;
    while (t < bound && model_busy()) begin
      tick();
      t++;
    end
    chk("drain_in_time", 0, int'(t < bound), 1);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [7:0]           data;
    logic [NI-1:0][11:0]  f;     // expected mid-bit samples, bit k = k-th bit
  } vec_t;

  vec_t       vecs [4];
  int         blen [NI];
  logic [7:0] rst_bytes [4];
  logic [11:0] cap [NI];
  int          bcnt [NI];
  int          nxt, t;

  initial begin
    vecs[0].data = 8'hAB; vecs[0].f = {12'hD56, 12'hF56, 12'hF56};
    vecs[1].data = 8'hC3; vecs[1].f = {12'hF86, 12'hD86, 12'hF86};
    vecs[2].data = 8'h0F; vecs[2].f = {12'hE1E, 12'hC1E, 12'hE1E};
    vecs[3].data = 8'hF0; vecs[3].f = {12'hFE0, 12'hDE0, 12'hFE0};
    blen[0] = 690; blen[1] = 828; blen[2] = 759;
    rst_bytes[0] = 8'h55; rst_bytes[1] = 8'hAA; rst_bytes[2] = 8'h12; rst_bytes[3] = 8'h34;

    vld = '0;
    dat = '0;
    cyc = 0;
    model_reset();

    // Reset held.
    repeat (3) tick();
    chk("rst_tx", 0, txs[0], 1);
    chk("rst_busy", 0, bsy[0], 0);
    chk("rst_level", 0, lvl[0], 0);
    chk("rst_ready", 0, rdy[0], 0);
    #2 rst = 1'b1;
    tick();
    chk("ready_after_release", 0, rdy[0], 1);

    // Reset mid-frame: 0x55 shifting, three bytes queued, hit during data bit 3.
    nxt = 0; t = 0;
    vld[0] = 1'b1; dat[0] = rst_bytes[0];
    while (nxt < 4 && t < 50) begin
      tick(); t++;
      if (last_acc[0]) begin
        nxt++;
        if (nxt < 4) dat[0] = rst_bytes[nxt];
        else vld[0] = 1'b0;
      end
    end
    chk("rst_seq_accepted", 0, nxt, 4);
    t = 0;
    while (cyc < fstart[0] + 4 * DIV + 30 && t < 1000) begin tick(); t++; end
    chk("mid_bit3_tx", 0, txs[0], 0);
    chk("mid_bit3_level", 0, lvl[0], 3);
    #2 rst = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      chk("async_tx", i, txs[i], 1);
      chk("async_busy", i, bsy[i], 0);
      chk("async_level", i, lvl[i], 0);
      chk("async_ready", i, rdy[i], 0);
    end
    repeat (2) tick();
    #2 rst = 1'b1;
    repeat (1500) tick();

    // Table rows, one byte every 1000 cycles (also the slow-producer case).
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NI; i++) begin
        chk("pre_idle_tx", i, txs[i], 1);
        chk("pre_idle_busy", i, bsy[i], 0);
        dat[i] = vecs[r].data;
      end
      vld = '1;
      tick();
      vld = '0;
      for (int i = 0; i < NI; i++) begin
        dat[i] = 8'($urandom);
        chk("tx_at_accept", i, txs[i], 1);
        chk("level_at_accept", i, lvl[i], 1);
      end
      tick();
      for (int i = 0; i < NI; i++) begin
        chk("tx_low_next_edge", i, txs[i], 0);
        cap[i]  = '1;
        bcnt[i] = 0;
      end
      for (int k = 0; k < 996; k++) begin
        for (int i = 0; i < NI; i++) begin
          if (k % DIV == DIV / 2 && k / DIV < 12) cap[i][k / DIV] = txs[i];
          if (bsy[i]) bcnt[i]++;
        end
        tick();
      end
      for (int i = 0; i < NI; i++) begin
        chk("frame_bits", i, cap[i], vecs[r].f[i]);
        chk("busy_cycles", i, bcnt[i], blen[i]);
      end
    end

    // Burst of 18 bytes into instance 0 with s_valid held high.
    nxt = 0; t = 0;
    vld[0] = 1'b1; dat[0] = 8'h00;
    while (nxt < 18 && t < 3000) begin
      tick(); t++;
      if (last_acc[0]) begin
        nxt++;
        if (nxt < 18) dat[0] = 8'(nxt);
        else vld[0] = 1'b0;
      end
      if (t == 25) begin
        chk("burst_accepted", 0, nxt, 17);
        chk("burst_level_full", 0, lvl[0], 16);
        chk("burst_ready_low", 0, rdy[0], 0);
      end
      if (t == 692) begin
        chk("pop_edge_ready", 0, rdy[0], 0);
        chk("pop_edge_level", 0, lvl[0], 15);
      end
      if (t == 693) chk("ready_reassert", 0, rdy[0], 1);
    end
    vld[0] = 1'b0;
    chk("burst_all_accepted", 0, nxt, 18);
    wait_idle(20000);

    // Random producers on all instances.
    for (int k = 0; k < 8000; k++) begin
      for (int i = 0; i < NI; i++) begin
        if (!vld[i] && $urandom_range(0, 39) == 0) begin
          vld[i] = 1'b1;
          dat[i] = 8'($urandom);
        end
      end
      tick();
      for (int i = 0; i < NI; i++) begin
        if (last_acc[i]) begin
          vld[i] = ($urandom_range(0, 3) == 0);
          dat[i] = 8'($urandom);
        end
      end
    end
    vld = '0;
    wait_idle(30000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
